proc_sequencer: RTL and testbench
=================================

# proc_sequencer

- Program sequencer that drives the 16-bit bus processor's `DIN`/`Run` inputs from a synchronous instruction memory, one instruction at a time, using the processor's `Done` as the handshake.
- Fetches each instruction word and, for `mvi` (opcode `IR[8:6]=001`), prefetches the immediate at PC+1, so both words are ready before `Run` is raised.
- Sits between program ROM/RAM and the processor instance and replaces the switch-driven `DIN`/`Run` on the board top level.

## Interface
- `ADDR_W`, 8, instruction memory address width; PC wraps modulo 2^ADDR_W.
- `EXEC_TIMEOUT`, 4, maximum cycles in EXEC without `Done` before FAULT.
- `Clock`  in  1  single clock; all state updates on posedge.
- `Resetn`  in  1  asynchronous, active-high reset. The name is the codebase's, but the polarity is high: 1 = reset.
- `Start`  in  1  level-sampled; starts execution from address 0 when in IDLE, HALT or FAULT.
- `MemAddr`  out  ADDR_W  memory read address.
- `MemRd`  out  1  read strobe; data returns on `MemData` one cycle later.
- `MemData`  in  16  memory read data.
- `DIN`  out  16  word presented to the processor.
- `Run`  out  1  processor run enable.
- `Done`  in  1  processor instruction-complete flag.
- `PC`  out  ADDR_W  address of the current instruction.
- `InstrCount`  out  16  retired instructions since Start; wraps at 16'hFFFF→0.
- `Halted`  out  1  high in HALT.
- `Fault`  out  1  high in FAULT.

## Operation
States: IDLE, FETCH, DECODE, FETCH_IMM, LOAD_IMM, ISSUE, EXEC, HALT, FAULT (plus WAIT_STEP under the macro).

- **Reset:**
  - Go to IDLE.
  - PC, `InstrCount`, instruction register and immediate register = 0.
  - All outputs 0.
- **IDLE / HALT / FAULT:** `Start`=1 → clear PC and `InstrCount` → FETCH. Otherwise hold.
- **FETCH:** `MemRd`=1, `MemAddr`=PC → DECODE.
- **DECODE:** sample `MemData` into the instruction register, then branch:
  - `MemData[15:9]`=7'h7F (HALT word): do not issue; → HALT, PC unchanged.
  - Opcode 001 (`mvi`): → FETCH_IMM.
  - Otherwise: → ISSUE.
- **FETCH_IMM:** `MemRd`=1, `MemAddr`=PC+1 (modulo) → LOAD_IMM.
- **LOAD_IMM:** sample `MemData` into the immediate register → ISSUE.
- **ISSUE:** `Run`=1, `DIN`=instruction register (processor step 0 latches the IR) → EXEC. Clear the timeout counter.
- **EXEC:**
  - Outputs: `Run`=1. `DIN` = immediate register for `mvi`, otherwise the instruction register.
  - If `Done`=1: PC += 2 for `mvi`, += 1 otherwise (modulo 2^ADDR_W); `InstrCount` += 1; → FETCH.
  - Else: timeout counter += 1. Reaching EXEC_TIMEOUT → FAULT with PC unchanged.
- **Outside ISSUE/EXEC:** `Run`=0 and `DIN`=0.
- **`MemRd`:** high only in FETCH and FETCH_IMM.
- **`Done` outside EXEC:** ignored.
- **`Start` outside IDLE/HALT/FAULT:** ignored.

## Timing
- Memory: address/strobe in cycle t, data sampled at the end of cycle t+1.
- Non-`mvi` instruction: FETCH, DECODE, ISSUE, then EXEC until `Done`. With a 1-cycle-EXEC `mv`, that is 4 cycles per instruction.
- `mvi`: adds 2 cycles (FETCH_IMM, LOAD_IMM).
- Add, sub and other ALU ops: `Done` appears in the 3rd EXEC cycle, giving 6 cycles per instruction.
- `Done` and timeout in the same cycle: `Done` wins.
- PC at 2^ADDR_W−1 plus `mvi`: the immediate is read from address 0 and the next PC is 1.
- Asynchronous reset mid-EXEC drops `Run` immediately, with no wait for `Done`.

## Configuration
- **`SEQ_SINGLE_STEP_EN` defined:**
  - Adds input `Step` (1 bit).
  - After each retirement, EXEC goes to WAIT_STEP instead of FETCH.
  - WAIT_STEP holds (`Run`=0) until `Step`=1, then → FETCH.
  - `Step` is level-sampled; a held `Step` runs continuously.
- **Not defined:** no `Step` port, no WAIT_STEP state; behaviour as above.

## Test plan
- Reset mid-EXEC: assert `Resetn`=1 → `Run`, `DIN`, `PC`, `MemRd`, `Halted`, `Fault` all 0 without a clock edge; state IDLE.
- Program {mv 0x0008 @0, HALT 0xFE00 @1}, `Start` pulse, `Done` returned 1 cycle after ISSUE:
  - `DIN`=0x0008 with `Run`=1 for 2 cycles.
  - Then `PC`=1, `InstrCount`=1, `Halted`=1 four cycles later.
  - `Run` is never high for the HALT word.
- mvi at address 0 {0x0040, 0x1234}:
  - ISSUE drives `DIN`=0x0040, EXEC drives `DIN`=0x1234.
  - After `Done`, `PC`=2.
  - `MemAddr` sequence is 0, 1, 2.
- Timeout: never assert `Done` → `Fault`=1 after EXEC_TIMEOUT=4 EXEC cycles, `PC` unchanged. A subsequent `Start` restarts at PC=0 with `InstrCount`=0.
- Wrap: ADDR_W=2, `mvi` at address 3 → immediate read from address 0, next `PC`=1.
- `SEQ_SINGLE_STEP_EN`: two `mv` instructions, `Step`=0 → stops after the first retirement with `Run`=0. A 1-cycle `Step` pulse → the second instruction issues and `InstrCount`=2.

Source files
------------

// File: rtl/proc_sequencer.sv
// Program sequencer: fetches instructions (plus the mvi immediate) from a synchronous
// memory and hands them to the bus processor over DIN/Run/Done. Optional macro: SEQ_SINGLE_STEP_EN.
module proc_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int EXEC_TIMEOUT = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              Step,
`endif
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic [15:0]       MemData,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] PC,
  output logic [15:0]       InstrCount,
  output logic              Halted,
  output logic              Fault
);

  localparam int TO_W = $clog2(EXEC_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(EXEC_TIMEOUT);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_FETCH_IMM = 4'd3;
  localparam logic [3:0] S_LOAD_IMM  = 4'd4;
  localparam logic [3:0] S_ISSUE     = 4'd5;
  localparam logic [3:0] S_EXEC      = 4'd6;
  localparam logic [3:0] S_HALT      = 4'd7;
  localparam logic [3:0] S_FAULT     = 4'd8;
`ifdef SEQ_SINGLE_STEP_EN
  localparam logic [3:0] S_WAIT_STEP = 4'd9;
`endif

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       imm_q, imm_d;
  logic [TO_W-1:0]   to_q, to_d;

  logic              is_mvi;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_step;
  logic [TO_W-1:0]   to_inc;
  logic [3:0]        retire_state;

  assign is_mvi   = (ir_q[8:6] == 3'b001);
  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign pc_step  = pc_q + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
  assign to_inc   = to_q + TO_W'(1);

`ifdef SEQ_SINGLE_STEP_EN
  assign retire_state = S_WAIT_STEP;
`else
  assign retire_state = S_FETCH;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE, S_HALT, S_FAULT: begin
        if (Start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = MemData;
        // HALT word is recognised before the opcode so it is never issued
        if (MemData[15:9] == 7'h7F)      state_d = S_HALT;
        else if (MemData[8:6] == 3'b001) state_d = S_FETCH_IMM;
        else                             state_d = S_ISSUE;
      end
      S_FETCH_IMM: state_d = S_LOAD_IMM;
      S_LOAD_IMM: begin
        imm_d   = MemData;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        to_d    = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Done takes priority over a timeout landing in the same cycle
        if (Done) begin
          pc_d    = pc_step;
          cnt_d   = cnt_q + 16'd1;
          state_d = retire_state;
        end else if (to_inc == TO_MAX) begin
          state_d = S_FAULT;
        end else begin
          to_d = to_inc;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_WAIT_STEP: begin
        if (Step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      to_q    <= to_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them without a clock edge
  always_comb begin
    MemRd   = 1'b0;
    MemAddr = '0;
    Run     = 1'b0;
    DIN     = '0;
    case (state_q)
      S_FETCH: begin
        MemRd   = 1'b1;
        MemAddr = pc_q;
      end
      S_FETCH_IMM: begin
        MemRd   = 1'b1;
        MemAddr = pc_plus1;
      end
      S_ISSUE: begin
        Run = 1'b1;
        DIN = ir_q;
      end
      S_EXEC: begin
        Run = 1'b1;
        DIN = is_mvi ? imm_q : ir_q;
      end
      default: ;
    endcase
  end

  assign PC         = pc_q;
  assign InstrCount = cnt_q;
  assign Halted     = (state_q == S_HALT);
  assign Fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_proc_sequencer.sv
// Randomized bench for proc_sequencer: the bench plays memory and processor and
// predicts every bus cycle from a program-level model (pc, retired count, latency).
module tb_proc_sequencer;
  localparam int AW = 8;
  localparam int TO = 4;

  logic          Clock = 1'b0;
  logic          Resetn, Start, MemRd, Run, Done, Halted, Fault;
  logic [AW-1:0] MemAddr, PC;
  logic [15:0]   MemData, DIN, InstrCount;
`ifdef SEQ_SINGLE_STEP_EN
  logic          Step;
`endif

  proc_sequencer #(.ADDR_W(AW), .EXEC_TIMEOUT(TO)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start),
`ifdef SEQ_SINGLE_STEP_EN
    .Step(Step),
`endif
    .MemAddr(MemAddr), .MemRd(MemRd), .MemData(MemData),
    .DIN(DIN), .Run(Run), .Done(Done), .PC(PC), .InstrCount(InstrCount),
    .Halted(Halted), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  logic [15:0]   mem [256];
  logic          rd_pend;
  logic [AW-1:0] addr_pend;
  logic [AW-1:0] pc_m;
  logic [15:0]   cnt_m;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock; memory answers a strobe from the previous cycle, otherwise drives junk
  task automatic step();
    @(posedge Clock);
    #1;
    if (rd_pend) MemData = mem[addr_pend];
    else         MemData = 16'($urandom);
    rd_pend   = MemRd;
    addr_pend = MemAddr;
  endtask

  task automatic do_reset();
    Resetn = 1'b1;
    step();
    step();
    Resetn = 1'b0;
  endtask

  function automatic logic [15:0] rnd_word(input bit allow_mvi);
    logic [15:0] w;
    w = 16'($urandom);
    while (w[15:9] == 7'h7F) w = 16'($urandom);
    if (!allow_mvi && w[8:6] == 3'b001) w[8:6] = 3'b000;
    return w;
  endfunction

  // lat_mode >= 0: fixed EXEC cycles until Done (0 = never); -1: random 1..4; -2: random, faults allowed
  function automatic int pick_lat(input int lat_mode);
    if (lat_mode >= 0) return lat_mode;
    if (lat_mode == -2 && $urandom_range(0, 15) == 0) return 0;
    return int'($urandom_range(1, TO));
  endfunction

  // Runs from IDLE/HALT/FAULT; result 0 = halted, 1 = faulted, 2 = max_instr retired (DUT left in FETCH)
  task automatic run_prog(input int lat_mode, input int max_instr, output int result);
    logic [15:0]   w, imm;
    logic [AW-1:0] pc1;
    bit            mvi;
    int            lat;
    Start = 1'b1;
    step();
    Start = 1'b0;
    pc_m  = '0;
    cnt_m = '0;
    result = 2;
    for (int n = 0; n < max_instr; n++) begin
      chk("fetch_rd", MemRd, 1);
      chk("fetch_addr", MemAddr, pc_m);
      chk("pc", PC, pc_m);
      chk("icount", InstrCount, cnt_m);
      chk("fetch_run", Run, 0);
      Done = 1'($urandom);
      Start = 1'($urandom);
      step();
      Start = 1'b0;
      w = mem[pc_m];
      chk("dec_rd", MemRd, 0);
      chk("dec_run", Run, 0);
      chk("dec_din", DIN, 0);
      Done = 1'($urandom);
      step();
      if (w[15:9] == 7'h7F) begin
        chk("halted", Halted, 1);
        chk("halt_pc", PC, pc_m);
        chk("halt_cnt", InstrCount, cnt_m);
        chk("halt_run", Run, 0);
        result = 0;
        return;
      end
      mvi = (w[8:6] == 3'b001);
      if (mvi) begin
        pc1 = pc_m + 8'd1;
        imm = mem[pc1];
        chk("imm_rd", MemRd, 1);
        chk("imm_addr", MemAddr, pc1);
        step();
        chk("ldimm_rd", MemRd, 0);
        chk("ldimm_run", Run, 0);
        step();
      end
      chk("issue_run", Run, 1);
      chk("issue_din", DIN, w);
      Done = 1'($urandom);
      step();
      lat = pick_lat(lat_mode);
      for (int k = 1; k <= TO; k++) begin
        chk("exec_run", Run, 1);
        chk("exec_din", DIN, mvi ? imm : w);
        chk("exec_fault", Fault, 0);
        Done = (k == lat);
        step();
        Done = 1'b0;
        if (k == lat) break;
      end
      if (lat == 0) begin
        chk("fault", Fault, 1);
        chk("fault_pc", PC, pc_m);
        chk("fault_cnt", InstrCount, cnt_m);
        chk("fault_run", Run, 0);
        chk("fault_din", DIN, 0);
        result = 1;
        return;
      end
      pc_m  = pc_m + (mvi ? 8'd2 : 8'd1);
      cnt_m = cnt_m + 16'd1;
`ifdef SEQ_SINGLE_STEP_EN
      begin
        int nw;
        nw = int'($urandom_range(0, 2));
        for (int i = 0; i < nw; i++) begin
          Step = 1'b0;
          chk("wait_run", Run, 0);
          chk("wait_cnt", InstrCount, cnt_m);
          step();
        end
        Step = 1'b1;
        chk("wait_run", Run, 0);
        step();
      end
`endif
    end
  endtask

  initial begin
    int res;
    Resetn = 1'b1; Start = 1'b0; Done = 1'b0; MemData = '0;
    rd_pend = 1'b0; addr_pend = '0;
`ifdef SEQ_SINGLE_STEP_EN
    Step = 1'b1;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 16'hFE00;
    step();
    step();
    chk("rst_run", Run, 0);
    chk("rst_din", DIN, 0);
    chk("rst_pc", PC, 0);
    chk("rst_rd", MemRd, 0);
    chk("rst_cnt", InstrCount, 0);
    chk("rst_halt", Halted, 0);
    chk("rst_fault", Fault, 0);
    Resetn = 1'b0;
    step();

    // mv then HALT, Done in first EXEC cycle
    mem[0] = 16'h0008; mem[1] = 16'hFE00;
    run_prog(1, 10, res);
    chk("p1_res", res, 0);

    // mvi with immediate, then HALT at 2
    mem[0] = 16'h0040; mem[1] = 16'h1234; mem[2] = 16'hFE00;
    run_prog(3, 10, res);
    chk("p2_res", res, 0);

    // Never Done -> FAULT; Start from FAULT restarts at 0
    mem[0] = 16'h0008;
    run_prog(0, 10, res);
    chk("p3_res", res, 1);
    mem[0] = 16'h0008; mem[1] = 16'h0010; mem[2] = 16'hFE00;
    run_prog(4, 10, res);
    chk("p4_res", res, 0);

    // Random programs
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = rnd_word(1);
      mem[$urandom_range(2, 30)] = 16'hFE00 | 16'($urandom_range(0, 511));
      run_prog(-2, 40, res);
      if (res == 2) do_reset();
    end

    // mvi at the last address: immediate from 0, next PC wraps to 1
    for (int i = 0; i < 255; i++) mem[i] = rnd_word(0);
    mem[255] = 16'h0040;
    run_prog(-1, 257, res);
    chk("wrap_res", res, 2);
    chk("wrap_cnt", cnt_m, 257);

    // Async reset in the middle of EXEC
    do_reset();
    mem[0] = 16'h0008; mem[1] = 16'h0010; mem[2] = 16'hFE00;
    run_prog(1, 1, res);
    Done = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_run", Run, 1);
    chk("pre_rst_pc", PC, 1);
    Resetn = 1'b1;
    #2;
    chk("arst_run", Run, 0);
    chk("arst_din", DIN, 0);
    chk("arst_pc", PC, 0);
    chk("arst_rd", MemRd, 0);
    chk("arst_halt", Halted, 0);
    chk("arst_fault", Fault, 0);
    chk("arst_cnt", InstrCount, 0);
    step();
    Resetn = 1'b0;
    step();
    run_prog(2, 10, res);
    chk("post_rst_res", res, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
